// File: rtl/heavy_bucket_stage.sv
// heavy_bucket_stage: one heavy-part table of the Elastic Sketch pipeline.
// Hashes keys to buckets, runs vote+/vote- with eviction, and queues losing keys for the next stage.
module heavy_bucket_stage #(
   parameter int                KEY_W        = 96,
   parameter int                CNT_W        = 16,
   parameter int                ADDR_W       = 12,
   parameter int                LAMBDA_SHIFT = 3,
   parameter logic [ADDR_W-1:0] HASH_SEED    = '0,
   parameter int                FIFO_AW      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_req,
   input  logic             in_wr,
   input  logic [KEY_W-1:0] in_key,
   input  logic [CNT_W-1:0] in_cnt,
   output logic             in_alf,
   output logic             out_wr,
   output logic [KEY_W-1:0] out_key,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_flag,
   input  logic             out_alf
);

   // state    | meaning
   // ST_CLEAR | sweeping zero buckets into addresses 0..DEPTH-1, input blocked
   // ST_RUN   | normal update; a pending clear waits here for stages 1-2 to empty

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int BKT_W  = KEY_W + 2*CNT_W + 1;
   localparam int REC_W  = KEY_W + CNT_W + 1;
   localparam int NSL    = (KEY_W + ADDR_W - 1) / ADDR_W;
   localparam int PAD_W  = NSL * ADDR_W;
   localparam int THR_W  = CNT_W + LAMBDA_SHIFT;
   localparam int FDEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] ALF_LVL = (FIFO_AW+1)'(FDEPTH - 4);
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(FDEPTH);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic                clr_pend_q, clr_pend_d;

   logic                s1_valid_q, s1_valid_d;
   logic [KEY_W-1:0]    s1_key_q;
   logic [CNT_W-1:0]    s1_cnt_q;
   logic [ADDR_W-1:0]   s1_idx_q, s1_idx_d;
   logic                s2_valid_q;
   logic [KEY_W-1:0]    s2_key_q;
   logic [CNT_W-1:0]    s2_cnt_q;
   logic [ADDR_W-1:0]   s2_idx_q;

   logic                lw_valid_q, lw_valid_d;
   logic [ADDR_W-1:0]   lw_addr_q, lw_addr_d;
   logic [BKT_W-1:0]    lw_data_q, lw_data_d;

   logic [BKT_W-1:0]    ram [DEPTH];
   logic [BKT_W-1:0]    ram_q;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_wa;
   logic [BKT_W-1:0]    ram_wd;

   logic [REC_W-1:0]    fifo_mem [FDEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]    fcnt_q, fcnt_d;
   logic                out_wr_q, out_wr_d;
   logic [REC_W-1:0]    out_rec_q, out_rec_d;

   logic [PAD_W-1:0]    key_pad;
   logic                accept;
   logic [BKT_W-1:0]    cur_bkt, upd_bkt;
   logic [KEY_W-1:0]    b_key;
   logic [CNT_W-1:0]    b_pos, b_neg, n_sum;
   logic                b_flag;
   logic                fwd_need, push, pop;
   logic [REC_W-1:0]    fwd_rec;

   assign key_pad = PAD_W'(in_key);
   assign accept  = in_wr && (state_q == ST_RUN) && !clr_pend_q;
   assign in_alf  = (state_q != ST_RUN) || clr_pend_q || (fcnt_q >= ALF_LVL);

   always_comb begin
      s1_idx_d = HASH_SEED;
      for (int i = 0; i < NSL; i++) begin
         s1_idx_d = s1_idx_d ^ key_pad[i*ADDR_W +: ADDR_W];
      end
      s1_valid_d = accept;
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_pend_d = clr_pend_q;
      case (state_q)
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (&clr_addr_q) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (clear_req) clr_pend_d = 1'b1;
            if (clr_pend_q && !s1_valid_q && !s2_valid_q) begin
               state_d    = ST_CLEAR;
               clr_pend_d = 1'b0;
               clr_addr_d = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // A write issued on the same edge as this packet's read is invisible in ram_q.
   always_comb begin
      cur_bkt  = (lw_valid_q && (lw_addr_q == s2_idx_q)) ? lw_data_q : ram_q;
      {b_key, b_pos, b_neg, b_flag} = cur_bkt;
      n_sum    = sat_add(b_neg, s2_cnt_q);
      upd_bkt  = cur_bkt;
      fwd_need = 1'b0;
      fwd_rec  = '0;
      if (b_pos == '0) begin
         upd_bkt = {s2_key_q, s2_cnt_q, {CNT_W{1'b0}}, 1'b0};
      end else if (b_key == s2_key_q) begin
         upd_bkt = {b_key, sat_add(b_pos, s2_cnt_q), b_neg, b_flag};
      end else if (THR_W'(n_sum) >= (THR_W'(b_pos) << LAMBDA_SHIFT)) begin
         upd_bkt  = {s2_key_q, s2_cnt_q, CNT_W'(1), 1'b1};
         fwd_need = 1'b1;
         fwd_rec  = {b_key, b_pos, b_flag};
      end else begin
         upd_bkt  = {b_key, b_pos, n_sum, b_flag};
         fwd_need = 1'b1;
         fwd_rec  = {s2_key_q, s2_cnt_q, 1'b0};
      end
   end

   always_comb begin
      if (state_q == ST_CLEAR) begin
         ram_we = 1'b1;
         ram_wa = clr_addr_q;
         ram_wd = '0;
      end else begin
         ram_we = s2_valid_q;
         ram_wa = s2_idx_q;
         ram_wd = upd_bkt;
      end
      lw_valid_d = lw_valid_q;
      lw_addr_d  = lw_addr_q;
      lw_data_d  = lw_data_q;
      if (ram_we) begin
         lw_valid_d = 1'b1;
         lw_addr_d  = ram_wa;
         lw_data_d  = ram_wd;
      end
   end

   always_comb begin
      push      = s2_valid_q && fwd_need && (fcnt_q != FULL_LVL);
      pop       = (fcnt_q != '0) && !out_alf;
      wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      fcnt_d    = fcnt_q;
      if (push && !pop) fcnt_d = fcnt_q + 1'b1;
      if (pop && !push) fcnt_d = fcnt_q - 1'b1;
      out_wr_d  = pop;
      out_rec_d = pop ? fifo_mem[rd_ptr_q] : out_rec_q;
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_wa] <= ram_wd;
      ram_q <= ram[s1_idx_q];
      if (push) fifo_mem[wr_ptr_q] <= fwd_rec;
   end

   always_ff @(posedge clk) begin
      s1_key_q  <= in_key;
      s1_cnt_q  <= in_cnt;
      s1_idx_q  <= s1_idx_d;
      s2_key_q  <= s1_key_q;
      s2_cnt_q  <= s1_cnt_q;
      s2_idx_q  <= s1_idx_q;
      lw_addr_q <= lw_addr_d;
      lw_data_q <= lw_data_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         clr_pend_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         lw_valid_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fcnt_q     <= '0;
         out_wr_q   <= 1'b0;
         out_rec_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         clr_pend_q <= clr_pend_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s1_valid_q;
         lw_valid_q <= lw_valid_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fcnt_q     <= fcnt_d;
         out_wr_q   <= out_wr_d;
         out_rec_q  <= out_rec_d;
      end
   end

   assign out_wr   = out_wr_q;
   assign out_key  = out_rec_q[REC_W-1 -: KEY_W];
   assign out_cnt  = out_rec_q[CNT_W:1];
   assign out_flag = out_rec_q[0];

endmodule

// File: tb/tb_heavy_bucket_stage.sv
// Directed bench for heavy_bucket_stage: hand-computed vote/eviction outcomes,
// latency, backpressure and table-clear timing.
module tb_heavy_bucket_stage;
   localparam int KEY_W = 96;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [CNT_W-1:0] cnt;
      logic             flag;
   } rec_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clear_req = 1'b0;
   logic             in_wr = 1'b0;
   logic [KEY_W-1:0] in_key = '0;
   logic [CNT_W-1:0] in_cnt = '0;
   logic             in_alf;
   logic             out_wr;
   logic [KEY_W-1:0] out_key;
   logic [CNT_W-1:0] out_cnt;
   logic             out_flag;
   logic             out_alf = 1'b0;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   sent_cyc = 0;
   rec_t got[$];
   rec_t exp_q[$];
   int   got_cyc[$];

   heavy_bucket_stage dut (
      .clk       (clk),
      .reset     (reset),
      .clear_req (clear_req),
      .in_wr     (in_wr),
      .in_key    (in_key),
      .in_cnt    (in_cnt),
      .in_alf    (in_alf),
      .out_wr    (out_wr),
      .out_key   (out_key),
      .out_cnt   (out_cnt),
      .out_flag  (out_flag),
      .out_alf   (out_alf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_wr === 1'b1) begin
         got.push_back({out_key, out_cnt, out_flag});
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [KEY_W-1:0] k, input logic [CNT_W-1:0] c, input logic clr);
      int g = 0;
      while (in_alf !== 1'b0 && g < 10000) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 10000) check("send_timeout", in_alf, 0);
      in_wr = 1'b1; in_key = k; in_cnt = c; clear_req = clr;
      @(posedge clk); #1;
      sent_cyc = cyc;
      in_wr = 1'b0; clear_req = 1'b0;
   endtask

   task automatic expect_rec(input logic [KEY_W-1:0] k, input logic [CNT_W-1:0] c, input logic f);
      exp_q.push_back({k, c, f});
   endtask

   task automatic wait_out(input int n);
      int g = 0;
      while (got.size() < n && g < 2000) begin
         @(posedge clk); #1;
         g++;
      end
   endtask

   task automatic compare_out(input string tag);
      repeat (6) @(posedge clk);
      #1;
      check({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s_rec%0d", tag, i), got[i], exp_q[i]);
      got.delete(); got_cyc.delete(); exp_q.delete();
   endtask

   task automatic alf_cycles(output int n);
      n = 0;
      while (in_alf === 1'b1 && n < 10000) begin
         n++;
         @(posedge clk); #1;
      end
   endtask

   logic [KEY_W-1:0] ka, kb, kz, kw;
   int n, b_cyc;
   bit released;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_alf", in_alf, 1);
      check("rst_out_wr", out_wr, 0);
      check("rst_out_key", out_key, 0);
      check("rst_out_cnt", out_cnt, 0);
      reset = 1'b0;
      alf_cycles(n);
      check("rst_clear_cycles", n, 4096);
      check("alf_low_after_clear", in_alf, 0);
      check("idle_no_output", got.size(), 0);

      // three hits on bucket 5, then a losing key in the same bucket
      ka = {84'h0, 12'h005};
      kb = {72'h0, 12'h001, 12'h004};
      repeat (3) send(ka, 16'd1, 1'b0);
      send(kb, 16'd1, 1'b0);
      b_cyc = sent_cyc;
      expect_rec(kb, 16'd1, 1'b0);
      wait_out(1);
      check("b_latency", (got_cyc.size() > 0) ? got_cyc[0] - b_cyc : -1, 3);
      compare_out("vote_neg");

      // eight back-to-back challengers: eighth reaches 8*vote_pos and evicts
      ka = {84'h0, 12'h0A0};
      kb = {72'h0, 12'h0F0, 12'h050};
      send(ka, 16'd1, 1'b0);
      for (int i = 0; i < 8; i++) send(kb, 16'd1, 1'b0);
      for (int i = 0; i < 7; i++) expect_rec(kb, 16'd1, 1'b0);
      expect_rec(ka, 16'd1, 1'b0);
      send(ka, 16'd1, 1'b0);
      expect_rec(ka, 16'd1, 1'b0);
      wait_out(9);
      compare_out("evict");

      // saturation of vote_pos, including a sum that would wrap to zero
      ka = {84'h0, 12'h123};
      kb = {72'h0, 12'h100, 12'h023};
      send(ka, 16'hFFFF, 1'b0);
      send(ka, 16'hFFFF, 1'b0);
      send(kb, 16'hFFFF, 1'b0);
      expect_rec(kb, 16'hFFFF, 1'b0);
      ka = {84'h0, 12'h124};
      kb = {72'h0, 12'h100, 12'h024};
      send(ka, 16'h8000, 1'b0);
      send(ka, 16'h8000, 1'b0);
      send(kb, 16'hFFFF, 1'b0);
      expect_rec(kb, 16'hFFFF, 1'b0);
      wait_out(2);
      compare_out("saturate");

      // backpressure: resident key with a large vote keeps every challenger losing
      send({84'h0, 12'h300}, 16'h1000, 1'b0);
      out_alf = 1'b1;
      released = 1'b0;
      for (int j = 0; j < 20; j++) begin
         if (!released && in_alf === 1'b1) begin
            check("bp_keys_before_alf", j, 14);
            released = 1'b1;
            out_alf = 1'b0;
         end
         kb = {72'h0, 12'(j + 1), 12'h300 ^ 12'(j + 1)};
         send(kb, 16'd1, 1'b0);
         expect_rec(kb, 16'd1, 1'b0);
      end
      check("bp_alf_rose", released, 1);
      out_alf = 1'b0;
      wait_out(20);
      compare_out("backpressure");

      // clear mid-stream with one record parked in the FIFO
      ka = {84'h0, 12'h7AB};
      kb = {72'h0, 12'h001, 12'h7AA};
      kz = {72'h0, 12'h002, 12'h7A9};
      kw = {72'h0, 12'h003, 12'h7A8};
      send(ka, 16'd1, 1'b0);
      out_alf = 1'b1;
      send(kb, 16'd1, 1'b1);
      expect_rec(kb, 16'd1, 1'b0);
      alf_cycles(n);
      check("clear_alf_cycles", n, 4099);
      send(kz, 16'd1, 1'b0);
      send(kw, 16'd1, 1'b0);
      expect_rec(kw, 16'd1, 1'b0);
      out_alf = 1'b0;
      wait_out(2);
      compare_out("clear");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
